// File: rtl/cdc_hs_pkg.sv
// Shared types and constants for the 4-phase req/ack CDC handshake controllers.
package cdc_hs_pkg;

  // Receive-side handshake state; encoding is fixed so debug probes stay stable.
  typedef enum logic [1:0] {
    HS_IDLE  = 2'd0,
    HS_VALID = 2'd1,
    HS_ACK   = 2'd2
  } hs_state_t;

  // Fewer than two flops gives no meaningful metastability settling time.
  localparam int unsigned HS_MIN_SYNC_STAGES = 2;

  // Clamp a requested synchronizer depth to the safe minimum.
  function automatic int unsigned hs_sync_stages(input int unsigned requested);
    return (requested < HS_MIN_SYNC_STAGES) ? HS_MIN_SYNC_STAGES : requested;
  endfunction

endpackage

// File: rtl/cdc_hs_rx_ctrl_if.sv
// Handshake bundle crossing into the B domain: the A-side req/data pair plus
// the B-side consumer valid/ready pair. The master side is whatever drives
// the request and consumes the word; the slave side is the rx controller.
interface cdc_hs_rx_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  req_a_i;
  logic [DATA_WIDTH-1:0] data_a_i;
  logic                  ack_b_o;
  logic [DATA_WIDTH-1:0] data_b_o;
  logic                  valid_b_o;
  logic                  ready_b_i;

  modport master (
    output req_a_i, data_a_i, ready_b_i,
    input  ack_b_o, data_b_o, valid_b_o
  );

  modport slave (
    input  req_a_i, data_a_i, ready_b_i,
    output ack_b_o, data_b_o, valid_b_o
  );
endinterface

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchronizer with asynchronous clear. Used for the
// incoming req here and for the returning ack on the transmit side.
module cdc_sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_in_b,
  input  logic arst_master,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain; bit 0 is the first stage.
  always_ff @(posedge clk_in_b or posedge arst_master) begin
    if (arst_master) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_hs_rx_ctrl.sv
// Receive-side controller for a 4-phase req/ack handshake. The level request
// is synchronized, the sender-held data bus is captured exactly once, offered
// to the local consumer with valid/ready, and ack is returned to the sender.
module cdc_hs_rx_ctrl
  import cdc_hs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 clk_in_b,
  input  logic                 arst_master,
  cdc_hs_rx_ctrl_if.slave      hs,
  output logic                 busy_b_o,
  output logic                 err_b_o,
  input  logic                 err_clr_i,
  output logic [CNT_WIDTH-1:0] xfer_cnt_o
);

  localparam int unsigned SYNC_EFF = hs_sync_stages(SYNC_STAGES);

  hs_state_t             state_q;
  logic                  req_sync;
  logic                  ack_q;
  logic                  valid_q;
  logic                  busy_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CNT_WIDTH-1:0]  xfer_cnt_q;
  logic                  violation;

  cdc_sync_bit #(
    .STAGES(SYNC_EFF)
  ) u_req_sync (
    .clk_in_b   (clk_in_b),
    .arst_master(arst_master),
    .d_i        (hs.req_a_i),
    .q_o        (req_sync)
  );

  // The sender withdrew req before we acknowledged: the word was offered but
  // the sender no longer guarantees it held the bus for us.
  assign violation = (state_q == HS_VALID) && !req_sync;

  // Handshake FSM with all outputs registered; data_a_i is only read on IDLE->VALID.
  always_ff @(posedge clk_in_b or posedge arst_master) begin
    if (arst_master) begin
      state_q    <= HS_IDLE;
      ack_q      <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      data_q     <= '0;
      xfer_cnt_q <= '0;
    end else begin
      case (state_q)
        HS_IDLE: begin
          if (req_sync) begin
            data_q  <= hs.data_a_i;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= HS_VALID;
          end
        end
        HS_VALID: begin
          if (hs.ready_b_i) begin
            valid_q    <= 1'b0;
            ack_q      <= 1'b1;
            xfer_cnt_q <= xfer_cnt_q + 1'b1;
            state_q    <= HS_ACK;
          end
        end
        HS_ACK: begin
          if (!req_sync) begin
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= HS_IDLE;
          end
        end
        default: begin
          ack_q   <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= HS_IDLE;
        end
      endcase
    end
  end

  // Sticky error flag; a new violation in the same cycle as a clear keeps it set.
  always_ff @(posedge clk_in_b or posedge arst_master) begin
    if (arst_master) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (err_q && !err_clr_i) || violation;
    end
  end

  assign hs.ack_b_o   = ack_q;
  assign hs.valid_b_o = valid_q;
  assign hs.data_b_o  = data_q;
  assign busy_b_o     = busy_q;
  assign err_b_o      = err_q;
  assign xfer_cnt_o   = xfer_cnt_q;

endmodule

// File: tb/tb_cdc_hs_rx_ctrl.sv
// Self-checking bench for cdc_hs_rx_ctrl: directed latency/backpressure/
// violation/reset steps plus randomized transfers checked against a queue of
// sent words and a modular transfer count.
module tb_cdc_hs_rx_ctrl;

  localparam int unsigned DW   = 8;
  localparam int unsigned SYNC = 2;
  localparam int unsigned CW   = 2;
  localparam int          CNT_MOD = 1 << CW;

  logic          clk_in_b;
  logic          arst_master;
  logic          busy_b_o;
  logic          err_b_o;
  logic          err_clr_i;
  logic [CW-1:0] xfer_cnt_o;

  cdc_hs_rx_ctrl_if #(.DATA_WIDTH(DW)) hs ();

  cdc_hs_rx_ctrl #(
    .DATA_WIDTH (DW),
    .SYNC_STAGES(SYNC),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk_in_b   (clk_in_b),
    .arst_master(arst_master),
    .hs         (hs),
    .busy_b_o   (busy_b_o),
    .err_b_o    (err_b_o),
    .err_clr_i  (err_clr_i),
    .xfer_cnt_o (xfer_cnt_o)
  );

  initial clk_in_b = 1'b0;
  always #5 clk_in_b = ~clk_in_b;

  int checks = 0;
  int errors = 0;
  int total  = 0;           // completed transfers since last reset
  logic [DW-1:0] exp_q[$];  // words the consumer should see, in order

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in_b);
    #1;
  endtask

  // Full 4-phase transfer of one word with rdy_dly cycles of consumer stall.
  task automatic send_word(input logic [DW-1:0] w, input int rdy_dly);
    int n;
    logic [DW-1:0] exp_w;
    exp_q.push_back(w);
    hs.data_a_i  = w;
    hs.req_a_i   = 1'b1;
    hs.ready_b_i = 1'b0;
    n = 0;
    while (hs.valid_b_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("valid_latency", 32'(n), 32'(SYNC + 1));
    chk("busy_in_valid", 32'(busy_b_o), 32'd1);
    chk("ack_low_in_valid", 32'(hs.ack_b_o), 32'd0);
    for (int i = 0; i < rdy_dly; i++) begin
      tick();
      chk("bp_valid", 32'(hs.valid_b_o), 32'd1);
      chk("bp_data", 32'(hs.data_b_o), 32'(w));
      chk("bp_ack", 32'(hs.ack_b_o), 32'd0);
      chk("bp_cnt", 32'(xfer_cnt_o), 32'(total % CNT_MOD));
    end
    exp_w = exp_q.pop_front();
    chk("rx_word", 32'(hs.data_b_o), 32'(exp_w));
    hs.ready_b_i = 1'b1;
    tick();
    total++;
    chk("ack_rise", 32'(hs.ack_b_o), 32'd1);
    chk("valid_fall", 32'(hs.valid_b_o), 32'd0);
    chk("xfer_cnt", 32'(xfer_cnt_o), 32'(total % CNT_MOD));
    hs.ready_b_i = 1'b0;
    hs.req_a_i   = 1'b0;
    n = 0;
    while (hs.ack_b_o !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    chk("ack_fall_latency", 32'(n), 32'(SYNC + 1));
    chk("busy_after_xfer", 32'(busy_b_o), 32'd0);
    $display("xfer word=%02h stall=%0d count=%0d", w, rdy_dly, xfer_cnt_o);
  endtask

  initial begin
    int n;
    arst_master  = 1'b1;
    hs.req_a_i   = 1'b0;
    hs.data_a_i  = '0;
    hs.ready_b_i = 1'b0;
    err_clr_i    = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_ack", 32'(hs.ack_b_o), 32'd0);
    chk("rst_valid", 32'(hs.valid_b_o), 32'd0);
    chk("rst_data", 32'(hs.data_b_o), 32'd0);
    chk("rst_busy", 32'(busy_b_o), 32'd0);
    chk("rst_err", 32'(err_b_o), 32'd0);
    chk("rst_cnt", 32'(xfer_cnt_o), 32'd0);
    arst_master = 1'b0;
    tick();
    tick();
    chk("idle_after_rst", 32'(busy_b_o), 32'd0);

    // Single transfer, then backpressure, then back-to-back words
    send_word(8'hA5, 0);
    send_word(8'h3C, 5);
    send_word(8'h01, 0);
    send_word(8'h02, 0);
    send_word(8'h03, 0);
    chk("b2b_err", 32'(err_b_o), 32'd0);
    chk("wrap_cnt", 32'(xfer_cnt_o), 32'(total % CNT_MOD));

    // Violation: req withdrawn while the word is still being offered
    hs.data_a_i = 8'h77;
    hs.req_a_i  = 1'b1;
    n = 0;
    while (hs.valid_b_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("viol_valid_latency", 32'(n), 32'(SYNC + 1));
    hs.req_a_i = 1'b0;
    n = 0;
    while (err_b_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("viol_err_latency", 32'(n), 32'(SYNC + 1));
    chk("viol_valid_held", 32'(hs.valid_b_o), 32'd1);
    chk("viol_data_held", 32'(hs.data_b_o), 32'h77);
    hs.ready_b_i = 1'b1;
    tick();
    total++;
    hs.ready_b_i = 1'b0;
    chk("viol_ack_pulse_hi", 32'(hs.ack_b_o), 32'd1);
    chk("viol_cnt", 32'(xfer_cnt_o), 32'(total % CNT_MOD));
    tick();
    chk("viol_ack_pulse_lo", 32'(hs.ack_b_o), 32'd0);
    chk("viol_busy", 32'(busy_b_o), 32'd0);
    chk("viol_err_sticky", 32'(err_b_o), 32'd1);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    chk("err_cleared", 32'(err_b_o), 32'd0);
    $display("violation word=77 err raised and cleared count=%0d", xfer_cnt_o);

    // Randomized transfers
    for (int k = 0; k < 8; k++) begin
      send_word(DW'($urandom), int'($urandom_range(0, 4)));
    end
    chk("rand_err", 32'(err_b_o), 32'd0);

    // Asynchronous reset landing between edges during HS_VALID
    hs.data_a_i = 8'h5A;
    hs.req_a_i  = 1'b1;
    n = 0;
    while (hs.valid_b_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("arst_pre_valid", 32'(hs.valid_b_o), 32'd1);
    #3;
    arst_master = 1'b1;
    #1;
    chk("arst_valid", 32'(hs.valid_b_o), 32'd0);
    chk("arst_data", 32'(hs.data_b_o), 32'd0);
    chk("arst_busy", 32'(busy_b_o), 32'd0);
    chk("arst_ack", 32'(hs.ack_b_o), 32'd0);
    chk("arst_cnt", 32'(xfer_cnt_o), 32'd0);
    total = 0;
    hs.req_a_i = 1'b0;
    tick();
    arst_master = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("post_arst_valid", 32'(hs.valid_b_o), 32'd0);
    chk("post_arst_busy", 32'(busy_b_o), 32'd0);
    $display("async reset during valid returned to idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
